// File: rtl/if_sweep_pkg.sv
// if_sweep_pkg: shared state encoding and widths for the IfEnt operand sweeper.
//   sweep_state_t : sweep FSM states
//   CHK_W         : checksum width
//   SETTLE_W      : settle counter width (SETTLE up to 15)
package if_sweep_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, HOLD, ADVANCE, FIN, DONE} sweep_state_t;
    localparam int CHK_W = 16;
    localparam int SETTLE_W = 4;
endpackage

// File: rtl/if_sweep_chk.sv
// if_sweep_chk: rotate-left-then-xor checksum over accepted result bytes.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (sweep start)
//   en         : fold din into the checksum (record accepted)
//   din        : sampled result value
//   chk        : running checksum
module if_sweep_chk
    import if_sweep_pkg::*;
#(
    parameter int NX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [NX-1:0]    din,
    output logic [CHK_W-1:0] chk
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk <= '0;
        else if (clr)
            chk <= '0;
        else if (en)
            chk <= {chk[CHK_W-2:0], chk[CHK_W-1]} ^ CHK_W'(din);
    end
endmodule

// File: rtl/if_operand_sweeper.sv
// if_operand_sweeper: sweeps every (A,B) grid point through an IfEnt datapath and streams {A,B,X} records.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin sweep (honoured in IDLE/DONE only)
//   busy, done        : sweep in progress / sweep complete (level)
//   a_out, b_out      : operands driven to the datapath
//   xin               : datapath result
//   res_valid/ready   : record handshake; res_a/res_b/res_x record payload
//   count             : records accepted since start (saturating)
//   chk               : result checksum, present only when IF_SWEEP_CHK_EN is defined, else 0
module if_operand_sweeper
    import if_sweep_pkg::*;
#(
    parameter int NX     = 8,
    parameter int B_STEP = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [NX-1:0]    a_out,
    output logic [NX-1:0]    b_out,
    input  logic [NX-1:0]    xin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NX-1:0]    res_a,
    output logic [NX-1:0]    res_b,
    output logic [NX-1:0]    res_x,
    output logic [2*NX:0]    count,
    output logic [CHK_W-1:0] chk
);
    sweep_state_t state, state_nx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [NX:0] b_sum;
    logic go, acc, carry;

    assign go    = start && (state == IDLE || state == DONE);
    assign acc   = res_valid && res_ready;
    // one extra bit so the carry out of B marks the end of a row
    assign b_sum = {1'b0, b_out} + (NX+1)'(B_STEP);
    assign carry = b_sum[NX];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = go ? DRIVE : state;
            DRIVE:      state_nx = (settle_cnt == SETTLE_W'(SETTLE - 1)) ? CAPTURE : DRIVE;
            CAPTURE:    state_nx = HOLD;
            HOLD:       state_nx = acc ? ADVANCE : HOLD;
            ADVANCE:    state_nx = (carry && &a_out) ? FIN : DRIVE;
            FIN:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            res_valid  <= 1'b0;
            res_a      <= '0;
            res_b      <= '0;
            res_x      <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == DRIVE) ? settle_cnt + 1'b1 : '0;
            if (go) begin
                a_out <= '0;
                b_out <= '0;
                count <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
            if (state == CAPTURE) begin
                res_a     <= a_out;
                res_b     <= b_out;
                res_x     <= xin;
                res_valid <= 1'b1;
            end
            if (state == HOLD && acc) begin
                res_valid <= 1'b0;
                if (!(&count))
                    count <= count + 1'b1;
            end
            if (state == ADVANCE) begin
                b_out <= carry ? '0 : b_sum[NX-1:0];
                if (carry)
                    a_out <= a_out + 1'b1;
            end
            if (state == FIN) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef IF_SWEEP_CHK_EN
    if_sweep_chk #(.NX(NX)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .en    (acc),
        .din   (res_x),
        .chk   (chk)
    );
`else
    assign chk = '0;
`endif
endmodule

// File: tb/tb_if_operand_sweeper.sv
// tb_if_operand_sweeper: self-checking bench for if_operand_sweeper with an IfEnt (kwarg=17) datapath model.
module tb_if_operand_sweeper;
    localparam int NX = 8;
    localparam int B_STEP = 64;
    localparam int SETTLE = 1;
    localparam int NPB = (256 + B_STEP - 1) / B_STEP;
    localparam int NREC = 256 * NPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic res_ready = 1'b0;
    logic busy, done, res_valid;
    logic [7:0] a_out, b_out, xin, res_a, res_b, res_x;
    logic [16:0] count;
    logic [15:0] chk;

    int n_cmp = 0;
    int n_err = 0;
    int rec_n = 0;
    int cyc = 0;
    int last_acc = 0;
    int gap = 0;
    bit rnd = 0;
    logic [15:0] chk_m = '0;
    logic [7:0] cap_a [NREC];
    logic [7:0] cap_b [NREC];
    logic [7:0] cap_x [NREC];

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] x;
    } vec_t;
    vec_t tbl [5];

    // IfEnt, kwarg=17: A>B -> A+16, A<B -> 2A-B+17, A==B -> A
    function automatic logic [7:0] ifent(logic [7:0] a, logic [7:0] b);
        int t;
        if (a > b) return a + 8'd16;
        if (a == b) return a;
        t = 2 * int'(a) - int'(b) + 17;
        return t[7:0];
    endfunction

    function automatic logic [15:0] chk_exp();
`ifdef IF_SWEEP_CHK_EN
        return chk_m;
`else
        return 16'h0;
`endif
    endfunction

    always #5 clk = ~clk;
    assign xin = ifent(a_out, b_out);

    if_operand_sweeper #(.NX(NX), .B_STEP(B_STEP), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .a_out     (a_out),
        .b_out     (b_out),
        .xin       (xin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_a     (res_a),
        .res_b     (res_b),
        .res_x     (res_x),
        .count     (count),
        .chk       (chk)
    );

    task automatic check(string nm, logic [95:0] act, logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with inputs settled: scores any record accepted on the coming
    // posedge, then advances one full cycle back to the next negedge.
    task automatic tick();
        logic [7:0] ea, eb, ex;
        if (rnd) res_ready = ($urandom_range(0, 3) != 0);
        if (res_valid && res_ready) begin
            if (rec_n >= NREC) begin
                check("extra_record", rec_n, NREC - 1);
            end else begin
                ea = 8'(rec_n / NPB);
                eb = 8'((rec_n % NPB) * B_STEP);
                ex = ifent(ea, eb);
                check("rec_a", res_a, ea);
                check("rec_b", res_b, eb);
                check("rec_x", res_x, ex);
                check("rec_count", count, rec_n);
                cap_a[rec_n] = res_a;
                cap_b[rec_n] = res_b;
                cap_x[rec_n] = res_x;
                chk_m = {chk_m[14:0], chk_m[15]} ^ {8'h00, ex};
                gap = cyc - last_acc;
                last_acc = cyc;
                rec_n++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(string nm);
        int n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        check(nm, res_valid, 1);
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (!done && n < 30000) begin
            tick();
            n++;
        end
        check(nm, done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        rec_n = 0;
        chk_m = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic check_zero(string nm);
        check({nm, "_ctl"}, {busy, done, res_valid, a_out, b_out, count}, 0);
        check({nm, "_rec"}, {res_a, res_b, res_x, chk}, 0);
    endtask

    initial begin
        int n, k;
        bit stable;
        logic [95:0] snap;
        tbl = '{'{0, 8'd0, 8'd0, 8'd0}, '{21, 8'd5, 8'd64, 8'd219}, '{23, 8'd5, 8'd192, 8'd91},
                '{24, 8'd6, 8'd0, 8'd22}, '{1023, 8'd255, 8'd192, 8'd15}};
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        // sweep 1: latency, throughput, backpressure, ignored START, random ready
        res_ready = 1'b1;
        pulse_start();
        check("busy_on_start", {busy, done}, 2'b10);
        n = 1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, SETTLE + 2);
        check("first_rec", {res_a, res_b}, 0);
        n = 0;
        while (rec_n < 12 && n < 200) begin
            tick();
            n++;
        end
        check("period", gap, SETTLE + 3);

        res_ready = 1'b0;
        wait_valid("hold_valid");
        snap = {res_valid, res_a, res_b, res_x, a_out, b_out, count};
        stable = 1;
        repeat (20) begin
            tick();
            if ({res_valid, res_a, res_b, res_x, a_out, b_out, count} !== snap) stable = 0;
        end
        check("hold_stable", stable, 1);
        res_ready = 1'b1;
        k = rec_n;
        tick();
        check("one_accept", rec_n, k + 1);
        check("valid_drop", res_valid, 0);

        repeat (5) tick();
        k = rec_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("start_ignored_busy", busy, 1);
        check("start_ignored_cnt", count > 17'(k), 1);

        rnd = 1;
        wait_done("done1");
        rnd = 0;
        res_ready = 1'b1;
        check("busy_off", busy, 0);
        check("final_count", count, NREC);
        check("records_seen", rec_n, NREC);
        check("chk1", chk, chk_exp());
        foreach (tbl[i]) begin
            check("tbl_a", cap_a[tbl[i].idx], tbl[i].a);
            check("tbl_b", cap_b[tbl[i].idx], tbl[i].b);
            check("tbl_x", cap_x[tbl[i].idx], tbl[i].x);
        end
        repeat (3) tick();
        check("done_level", {busy, done}, 2'b01);

        // sweep 2: checksum clear, reset mid-HOLD, restart
        res_ready = 1'b0;
        pulse_start();
        check("chk_clr", chk, 0);
        check("done_clr", {busy, done}, 2'b10);
        wait_valid("valid2");
        check("first_rec2", {res_a, res_b}, 0);
        rst_n = 1'b0;
        tick();
        check_zero("midhold_reset");
        rst_n = 1'b1;
        tick();
        check_zero("post_reset");
        res_ready = 1'b1;
        pulse_start();
        wait_valid("valid3");
        check("restart_rec", {res_a, res_b}, 0);
        wait_done("done3");
        check("final_count3", count, NREC);
        check("chk3", chk, chk_exp());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
